// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 device-to-host receive path:
// receiver state encoding, error codes reported on err_code,
// frame geometry and the well-known ACK byte.
package ps2_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    // Error codes presented on err_code
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_START   = 3'd1;
    localparam logic [2:0] ERR_PARITY  = 3'd2;
    localparam logic [2:0] ERR_STOP    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Acknowledge byte a device returns after every host command
    localparam logic [7:0] ACK_BYTE = 8'hFA;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter
// Synchronizes the raw PS/2 clock pad, removes glitches and produces a
// one-cycle pulse on every filtered high-to-low transition. Shared with the
// host-to-device transmitter, which shifts its bits on the same pulse.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   ps2_c     in   raw PS/2 clock pad
//   fall_edge out  one-cycle pulse per filtered falling edge
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_c,
    output logic fall_edge
);

    logic [1:0]            c_sync;
    logic [FILTER_LEN-1:0] c_hist;
    logic                  c_filt;

    // Everything resets to the idle-high bus level so that releasing reset
    // can never look like a falling edge. The filtered level only moves once
    // the whole history agrees; the edge pulse is registered together with
    // the level change so it lines up exactly with the new low level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync    <= 2'b11;
            c_hist    <= '1;
            c_filt    <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            c_sync    <= {c_sync[0], ps2_c};
            c_hist    <= {c_hist[FILTER_LEN-2:0], c_sync[1]};
            fall_edge <= 1'b0;
            if (c_hist == '0) begin
                c_filt    <= 1'b0;
                fall_edge <= c_filt;
            end else if (c_hist == '1) begin
                c_filt <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Device-to-host PS/2 frame receiver. Captures start/data/parity/stop frames
// on the filtered PS/2 clock, validates them and delivers each good byte with
// a one-cycle strobe. Frame errors are flagged with a one-cycle pulse and a
// sticky error code.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   ps2_c     in   raw PS/2 clock pad
//   ps2_d     in   raw PS/2 data pad
//   rx_en     in   receive enable, low while the transmitter owns the bus
//   fall_edge out  filtered ps2_c falling-edge pulse (also used by the transmitter)
//   rx_data   out  last correctly received byte
//   rx_done   out  one-cycle pulse when rx_data updates
//   rx_err    out  one-cycle pulse on a frame error
//   err_code  out  0 none, 1 start, 2 parity, 3 stop, 4 timeout
//   rx_idle   out  high while waiting for a start bit
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TO_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_c,
    input  logic       ps2_d,
    input  logic       rx_en,
    output logic       fall_edge,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_err,
    output logic [2:0] err_code,
    output logic       rx_idle
);

    localparam int SHIFT_BITS = FRAME_BITS - 1;

    rx_state_t             state;
    rx_state_t             next_state;
    logic [1:0]            d_sync;
    logic                  d_bit;
    logic [SHIFT_BITS-1:0] shreg;
    logic [3:0]            bit_cnt;
    logic [TO_W-1:0]       timer;
    logic                  start_ok;
    logic                  start_bad;
    logic                  last_bit;
    logic                  timeout_hit;
    logic                  done_set;
    logic                  err_set;
    logic [2:0]            code_set;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_c     (ps2_c),
        .fall_edge (fall_edge)
    );

    // Data line synchronizer, idle-high after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_sync <= 2'b11;
        end else begin
            d_sync <= {d_sync[0], ps2_d};
        end
    end

    assign d_bit     = d_sync[1];
    assign start_ok  = fall_edge && rx_en && !d_bit;
    assign start_bad = fall_edge && rx_en && d_bit;
    assign last_bit  = (bit_cnt == 4'(SHIFT_BITS - 1));

    // timer holds the number of cycles since the most recent edge, with the
    // edge cycle itself counted as cycle 0; it therefore reloads with 1.
    assign timeout_hit = !fall_edge && (timer == TO_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping rx_en during a frame wins over every other event
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                if (!rx_en) begin
                    next_state = IDLE;
                end else if (fall_edge && last_bit) begin
                    next_state = CHECK;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            CHECK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: rx_idle directly, plus the result that gets registered
    // onto rx_done/rx_err/err_code. Parity is judged before the stop bit.
    always_comb begin
        rx_idle  = (state == IDLE);
        done_set = 1'b0;
        err_set  = 1'b0;
        code_set = ERR_NONE;
        case (state)
            IDLE: begin
                if (start_bad) begin
                    err_set  = 1'b1;
                    code_set = ERR_START;
                end
            end
            RECV: begin
                if (rx_en && timeout_hit) begin
                    err_set  = 1'b1;
                    code_set = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (!odd_parity_ok(shreg[7:0], shreg[8])) begin
                    err_set  = 1'b1;
                    code_set = ERR_PARITY;
                end else if (!shreg[9]) begin
                    err_set  = 1'b1;
                    code_set = ERR_STOP;
                end else begin
                    done_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Frame datapath and registered result outputs. Bits arrive LSB first,
    // so each new bit enters at the top and the frame settles with data in
    // [7:0], parity in [8] and stop in [9]. rx_data only moves with rx_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            timer    <= '0;
            rx_data  <= 8'h00;
            rx_done  <= 1'b0;
            rx_err   <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            rx_done <= done_set;
            rx_err  <= err_set;
            if (err_set) begin
                err_code <= code_set;
            end else if (done_set) begin
                err_code <= ERR_NONE;
                rx_data  <= shreg[7:0];
            end

            case (state)
                IDLE: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    timer   <= TO_W'(1);
                end
                RECV: begin
                    if (fall_edge) begin
                        shreg   <= {d_bit, shreg[SHIFT_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        timer   <= TO_W'(1);
                    end else begin
                        timer <= timer + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame
// Self-checking bench for ps2_rx_frame. Frames are driven like a PS/2 device
// would (data set while the clock is high, clock held low for half a bit).
// Each frame pushes its predicted outcome onto a queue; a monitor pops and
// compares whenever the receiver reports rx_done or rx_err.
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int TB_FILTER  = 8;
    localparam int TB_TIMEOUT = 1000;
    localparam int HALF_BIT   = 100;
    localparam int GAP        = 300;

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        logic [7:0] data;
        int         latency;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_c = 1'b1;
    logic       ps2_d = 1'b1;
    logic       rx_en = 1'b1;
    logic       fall_edge;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic [2:0] err_code;
    logic       rx_idle;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         fe_count = 0;
    int         cyc = 0;
    int         last_fe_cyc = 0;
    logic [7:0] last_good = 8'h00;

    ps2_rx_frame #(
        .FILTER_LEN     (TB_FILTER),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .TO_W           (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_c     (ps2_c),
        .ps2_d     (ps2_d),
        .rx_en     (rx_en),
        .fall_edge (fall_edge),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .err_code  (err_code),
        .rx_idle   (rx_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Predict the receiver's verdict for a complete frame and queue it
    task automatic expectFrame(input logic [7:0] data, input logic parity, input logic stop);
        exp_t e;
        e.latency = -1;
        if (((^data) ^ parity) != 1'b1) begin
            e.is_err = 1'b1; e.code = ERR_PARITY; e.data = last_good;
        end else if (!stop) begin
            e.is_err = 1'b1; e.code = ERR_STOP; e.data = last_good;
        end else begin
            e.is_err = 1'b0; e.code = ERR_NONE; e.data = data;
            last_good = data;
        end
        exp_q.push_back(e);
    endtask

    task automatic expectError(input logic [2:0] code, input int latency);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.data = last_good; e.latency = latency;
        exp_q.push_back(e);
    endtask

    // Drive the first nbits bits of a frame, then leave the bus idle for GAP cycles
    task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic stop, input int nbits);
        logic [FRAME_BITS-1:0] bits;
        bits = {stop, parity, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_d = bits[i];
            waitCycles(HALF_BIT);
            ps2_c = 1'b0;
            waitCycles(HALF_BIT);
            ps2_c = 1'b1;
        end
        ps2_d = 1'b1;
        waitCycles(GAP);
    endtask

    // Scoreboard monitor: every result strobe must match the oldest prediction
    always @(negedge clk) begin
        if (!rst) begin
            if (fall_edge) begin
                fe_count++;
                last_fe_cyc = cyc;
            end
            if (rx_done && rx_err) begin
                checkOutput("done_err_exclusive", 32'd1, 32'd0);
            end
            if (rx_done || rx_err) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", {31'd0, rx_err}, {31'd0, !rx_err});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("event_is_err", {31'd0, rx_err}, {31'd0, e.is_err});
                    checkOutput("err_code", {29'd0, err_code}, {29'd0, e.code});
                    checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    if (e.latency >= 0) begin
                        checkOutput("timeout_latency", cyc - last_fe_cyc, e.latency);
                    end
                end
            end
        end
    end

    initial begin
        #50_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        waitCycles(5);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("reset_rx_done", {31'd0, rx_done}, 32'd0);
        checkOutput("reset_rx_err", {31'd0, rx_err}, 32'd0);
        checkOutput("reset_err_code", {29'd0, err_code}, 32'd0);
        checkOutput("reset_fall_edge", {31'd0, fall_edge}, 32'd0);
        checkOutput("reset_rx_idle", {31'd0, rx_idle}, 32'd1);
        rst = 1'b0;
        waitCycles(20);
        checkOutput("idle_no_edge", fe_count, 0);

        // ACK byte, valid frame
        fe_count = 0;
        expectFrame(ACK_BYTE, ~^ACK_BYTE, 1'b1);
        applyStimulus(ACK_BYTE, ~^ACK_BYTE, 1'b1, FRAME_BITS);
        checkOutput("ack_edge_count", fe_count, FRAME_BITS);
        checkOutput("ack_rx_data", {24'd0, rx_data}, {24'd0, ACK_BYTE});
        checkOutput("ack_pending", exp_q.size(), 0);

        // Wrong parity
        expectFrame(8'hAA, 1'b0, 1'b1);
        applyStimulus(8'hAA, 1'b0, 1'b1, FRAME_BITS);
        checkOutput("parity_code_held", {29'd0, err_code}, {29'd0, ERR_PARITY});
        checkOutput("parity_data_kept", {24'd0, rx_data}, {24'd0, ACK_BYTE});

        // Bad stop bit, then a valid all-zero byte
        expectFrame(8'h55, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0, FRAME_BITS);
        checkOutput("stop_code_held", {29'd0, err_code}, {29'd0, ERR_STOP});
        expectFrame(8'h00, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b1, 1'b1, FRAME_BITS);
        checkOutput("zero_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("zero_err_code", {29'd0, err_code}, {29'd0, ERR_NONE});

        // Glitch one sample short of the filter length: must vanish
        fe_count = 0;
        ps2_c = 1'b0;
        waitCycles(TB_FILTER - 1);
        ps2_c = 1'b1;
        waitCycles(40);
        checkOutput("short_glitch_edges", fe_count, 0);
        checkOutput("short_glitch_idle", {31'd0, rx_idle}, 32'd1);

        // Glitch of exactly the filter length: one edge, seen as a start bit of 1
        expectError(ERR_START, -1);
        ps2_c = 1'b0;
        waitCycles(TB_FILTER);
        ps2_c = 1'b1;
        waitCycles(40);
        checkOutput("full_glitch_edges", fe_count, 1);
        checkOutput("start_err_pending", exp_q.size(), 0);

        // Clock stops after 5 bits: timeout error TB_TIMEOUT cycles after the 5th edge
        expectError(ERR_TIMEOUT, TB_TIMEOUT);
        applyStimulus(8'h0F, 1'b1, 1'b1, 5);
        waitCycles(TB_TIMEOUT);
        checkOutput("timeout_pending", exp_q.size(), 0);
        checkOutput("timeout_idle", {31'd0, rx_idle}, 32'd1);
        expectFrame(8'h3C, 1'b1, 1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b1, FRAME_BITS);
        checkOutput("after_timeout_data", {24'd0, rx_data}, 32'h3C);

        // rx_en dropped after 3 bits: silent abort
        applyStimulus(8'hC3, 1'b1, 1'b1, 3);
        checkOutput("mid_frame_busy", {31'd0, rx_idle}, 32'd0);
        rx_en = 1'b0;
        waitCycles(1);
        checkOutput("abort_idle", {31'd0, rx_idle}, 32'd1);
        waitCycles(TB_TIMEOUT + 50);
        checkOutput("abort_no_event", exp_q.size(), 0);
        checkOutput("abort_code_kept", {29'd0, err_code}, {29'd0, ERR_NONE});
        rx_en = 1'b1;

        // Reset mid-frame
        applyStimulus(8'h81, 1'b0, 1'b1, 4);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midrst_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("midrst_rx_idle", {31'd0, rx_idle}, 32'd1);
        checkOutput("midrst_err_code", {29'd0, err_code}, 32'd0);
        last_good = 8'h00;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("release_no_edge", {31'd0, fall_edge}, 32'd0);
        waitCycles(20);
        expectFrame(8'h81, 1'b1, 1'b1);
        applyStimulus(8'h81, 1'b1, 1'b1, FRAME_BITS);
        checkOutput("after_reset_data", {24'd0, rx_data}, 32'h81);
        checkOutput("final_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
